// File: rtl/car_crossroad_scheduler_pkg.sv
// ============================================================================
// Module : car_types_pkg
// Brief  : Shared light/phase types and helpers for the crossroad scheduler.
// Rev    : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

package car_types_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } strafic_light_t;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED_BA   = 3'd5
    } crossroad_phase_t;

    // The timer must reach the longest phase bound it is ever compared with.
    function automatic int car_timer_w(int max_green, int yellow, int all_red);
        int m;
        m = max_green;
        if (yellow > m)  m = yellow;
        if (all_red > m) m = all_red;
        return $clog2(m + 1);
    endfunction

    localparam int CAR_TIMER_W = car_timer_w(16, 2, 1);

    function automatic crossroad_phase_t next_phase(crossroad_phase_t p);
        case (p)
            A_GREEN:  return A_YELLOW;
            A_YELLOW: return RED_AB;
            RED_AB:   return B_GREEN;
            B_GREEN:  return B_YELLOW;
            B_YELLOW: return RED_BA;
            default:  return A_GREEN;
        endcase
    endfunction

    function automatic strafic_light_t light_of(crossroad_phase_t p, logic road_a);
        case (p)
            A_GREEN:  return road_a ? GREEN  : RED;
            A_YELLOW: return road_a ? YELLOW : RED;
            B_GREEN:  return road_a ? RED    : GREEN;
            B_YELLOW: return road_a ? RED    : YELLOW;
            default:  return RED;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/car_crossroad_scheduler_if.sv
// ============================================================================
// Module : car_crossroad_if
// Brief  : Sensor/control inputs and light/counter outputs of the scheduler.
//          Optional pass statistics when CAR_CROSSROAD_STATS_EN is defined.
// Rev    : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

interface car_crossroad_if #(
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 4
);
    import car_types_pkg::*;

    logic                       tick_in;
    logic [NUM_LANES-1:0]       car_arrived_a;
    logic [NUM_LANES-1:0]       car_arrived_b;
    logic                       car_pass_in;
    logic                       force_switch_in;
    strafic_light_t             light_a;
    strafic_light_t             light_b;
    crossroad_phase_t           phase;
    logic [NUM_LANES*CNT_W-1:0] count_a;
    logic [NUM_LANES*CNT_W-1:0] count_b;
    logic [NUM_LANES-1:0]       overflow_a;
    logic [NUM_LANES-1:0]       overflow_b;
`ifdef CAR_CROSSROAD_STATS_EN
    logic [15:0]                passed_a;
    logic [15:0]                passed_b;

    modport master (
        output tick_in, car_arrived_a, car_arrived_b, car_pass_in, force_switch_in,
        input  light_a, light_b, phase, count_a, count_b, overflow_a, overflow_b,
        input  passed_a, passed_b
    );
    modport slave (
        input  tick_in, car_arrived_a, car_arrived_b, car_pass_in, force_switch_in,
        output light_a, light_b, phase, count_a, count_b, overflow_a, overflow_b,
        output passed_a, passed_b
    );
`else
    modport master (
        output tick_in, car_arrived_a, car_arrived_b, car_pass_in, force_switch_in,
        input  light_a, light_b, phase, count_a, count_b, overflow_a, overflow_b
    );
    modport slave (
        input  tick_in, car_arrived_a, car_arrived_b, car_pass_in, force_switch_in,
        output light_a, light_b, phase, count_a, count_b, overflow_a, overflow_b
    );
`endif

endinterface

`default_nettype wire

// File: rtl/car_crossroad_scheduler_lane.sv
// ============================================================================
// Module : car_lane_counter
// Brief  : Saturating per-lane queue counter with sticky overflow flag.
// Rev    : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module car_lane_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_i,
    input  logic             depart_en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             w_inc, w_dec;

    always_comb begin
        w_inc      = arrive_i && (count_q != C_CNT_MAX);
        w_dec      = depart_en_i && (count_q != '0);
        count_d    = count_q;
        if (w_inc && !w_dec) begin
            count_d = count_q + 1'b1;
        end else if (w_dec && !w_inc) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q || (arrive_i && (count_q == C_CNT_MAX));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/car_crossroad_scheduler.sv
// ============================================================================
// Module : car_crossroad_scheduler
// Brief  : Demand-driven six-phase crossroad light FSM with per-lane queues.
//          Macro CAR_CROSSROAD_STATS_EN adds passed_a/passed_b counters.
// Rev    : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module car_crossroad_scheduler
    import car_types_pkg::*;
#(
    parameter int NUM_LANES       = 2,
    parameter int CNT_W           = 4,
    parameter int MIN_GREEN_TICKS = 4,
    parameter int MAX_GREEN_TICKS = 16,
    parameter int YELLOW_TICKS    = 2,
    parameter int ALL_RED_TICKS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    car_crossroad_if.slave bus_if
);

    localparam int TIMER_W = car_timer_w(MAX_GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS);
    localparam int TINC_W  = TIMER_W + 1;

    localparam logic [TINC_W-1:0]  C_MIN_GREEN = TINC_W'(MIN_GREEN_TICKS);
    localparam logic [TINC_W-1:0]  C_MAX_GREEN = TINC_W'(MAX_GREEN_TICKS);
    localparam logic [TINC_W-1:0]  C_YELLOW    = TINC_W'(YELLOW_TICKS);
    localparam logic [TINC_W-1:0]  C_ALL_RED   = TINC_W'(ALL_RED_TICKS);
    localparam logic [TIMER_W-1:0] C_TIMER_SAT = TIMER_W'(MAX_GREEN_TICKS);

    crossroad_phase_t           phase_q;
    crossroad_phase_t           w_next_phase;
    strafic_light_t             light_a_q, light_b_q;
    logic [TIMER_W-1:0]         timer_q;
    logic                       pending_q;

    logic [TINC_W-1:0]          w_tinc;
    logic                       w_a_green, w_b_green, w_green;
    logic                       w_min_met, w_max_met;
    logic                       w_dem_a, w_dem_b;
    logic                       w_phase_done;
    logic                       w_dep_a, w_dep_b;
    logic [NUM_LANES*CNT_W-1:0] w_count_a, w_count_b;
    logic [NUM_LANES-1:0]       w_ovf_a, w_ovf_b;

    assign w_tinc       = {1'b0, timer_q} + TINC_W'(1);
    assign w_a_green    = (phase_q == A_GREEN);
    assign w_b_green    = (phase_q == B_GREEN);
    assign w_green      = w_a_green || w_b_green;
    assign w_min_met    = (w_tinc >= C_MIN_GREEN);
    assign w_max_met    = (w_tinc >= C_MAX_GREEN);
    assign w_dem_a      = |w_count_a;
    assign w_dem_b      = |w_count_b;
    assign w_next_phase = next_phase(phase_q);

    // Departures only happen on the road currently showing green.
    assign w_dep_a = bus_if.car_pass_in && w_a_green;
    assign w_dep_b = bus_if.car_pass_in && w_b_green;

    always_comb begin
        w_phase_done = 1'b0;
        case (phase_q)
            A_GREEN:  w_phase_done = w_min_met &&
                                     (pending_q || (w_dem_b && !w_dem_a) || (w_max_met && w_dem_b));
            B_GREEN:  w_phase_done = w_min_met &&
                                     (pending_q || (w_dem_a && !w_dem_b) || (w_max_met && w_dem_a));
            A_YELLOW,
            B_YELLOW: w_phase_done = (w_tinc == C_YELLOW);
            default:  w_phase_done = (w_tinc == C_ALL_RED);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= A_GREEN;
            timer_q   <= '0;
            pending_q <= 1'b0;
            light_a_q <= GREEN;
            light_b_q <= RED;
        end else if (bus_if.tick_in && w_phase_done) begin
            phase_q   <= w_next_phase;
            timer_q   <= '0;
            pending_q <= 1'b0;
            light_a_q <= light_of(w_next_phase, 1'b1);
            light_b_q <= light_of(w_next_phase, 1'b0);
        end else begin
            // Saturation only matters while green may hold indefinitely.
            if (bus_if.tick_in && (!w_green || (timer_q != C_TIMER_SAT))) begin
                timer_q <= w_tinc[TIMER_W-1:0];
            end
            if (w_green && bus_if.force_switch_in) begin
                pending_q <= 1'b1;
            end
        end
    end

`ifdef CAR_CROSSROAD_STATS_EN
    logic [NUM_LANES-1:0] w_dec_a, w_dec_b;
    logic [15:0]          passed_a_q, passed_b_q;
`endif

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            car_lane_counter #(.CNT_W(CNT_W)) u_lane_a (
                .clk         (clk),
                .rst         (rst),
                .arrive_i    (bus_if.car_arrived_a[i]),
                .depart_en_i (w_dep_a),
                .count_o     (w_count_a[i*CNT_W +: CNT_W]),
                .overflow_o  (w_ovf_a[i])
            );
            car_lane_counter #(.CNT_W(CNT_W)) u_lane_b (
                .clk         (clk),
                .rst         (rst),
                .arrive_i    (bus_if.car_arrived_b[i]),
                .depart_en_i (w_dep_b),
                .count_o     (w_count_b[i*CNT_W +: CNT_W]),
                .overflow_o  (w_ovf_b[i])
            );
`ifdef CAR_CROSSROAD_STATS_EN
            assign w_dec_a[i] = w_dep_a && (w_count_a[i*CNT_W +: CNT_W] != '0);
            assign w_dec_b[i] = w_dep_b && (w_count_b[i*CNT_W +: CNT_W] != '0);
`endif
        end
    endgenerate

`ifdef CAR_CROSSROAD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passed_a_q <= '0;
            passed_b_q <= '0;
        end else begin
            passed_a_q <= passed_a_q + 16'($countones(w_dec_a));
            passed_b_q <= passed_b_q + 16'($countones(w_dec_b));
        end
    end

    assign bus_if.passed_a = passed_a_q;
    assign bus_if.passed_b = passed_b_q;
`endif

    assign bus_if.phase      = phase_q;
    assign bus_if.light_a    = light_a_q;
    assign bus_if.light_b    = light_b_q;
    assign bus_if.count_a    = w_count_a;
    assign bus_if.count_b    = w_count_b;
    assign bus_if.overflow_a = w_ovf_a;
    assign bus_if.overflow_b = w_ovf_b;

endmodule

`default_nettype wire

// File: tb/tb_car_crossroad_scheduler.sv
// ============================================================================
// Module : tb_car_crossroad_scheduler
// Brief  : Directed scoreboard bench for car_crossroad_scheduler (default params).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_car_crossroad_scheduler;
    import car_types_pkg::*;

    localparam int NL = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    car_crossroad_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

    car_crossroad_scheduler #(
        .NUM_LANES       (NL),
        .CNT_W           (CW),
        .MIN_GREEN_TICKS (4),
        .MAX_GREEN_TICKS (16),
        .YELLOW_TICKS    (2),
        .ALL_RED_TICKS   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    typedef struct packed {
        crossroad_phase_t ph;
        strafic_light_t   la;
        strafic_light_t   lb;
        logic [7:0]       ca;
        logic [7:0]       cb;
        logic [1:0]       oa;
        logic [1:0]       ob;
    } exp_t;

    exp_t             sb_q[$];
    int               checks = 0;
    int               errors = 0;

    crossroad_phase_t e_ph;
    logic [7:0]       e_ca, e_cb;
    logic [1:0]       e_oa, e_ob;

    function automatic strafic_light_t exp_light(crossroad_phase_t p, bit road_a);
        if (p == A_GREEN)  return road_a ? GREEN  : RED;
        if (p == A_YELLOW) return road_a ? YELLOW : RED;
        if (p == B_GREEN)  return road_a ? RED    : GREEN;
        if (p == B_YELLOW) return road_a ? RED    : YELLOW;
        return RED;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_t x;
        x.ph = e_ph;
        x.la = exp_light(e_ph, 1'b1);
        x.lb = exp_light(e_ph, 1'b0);
        x.ca = e_ca;
        x.cb = e_cb;
        x.oa = e_oa;
        x.ob = e_ob;
        sb_q.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".phase"},   32'(bus.phase),      32'(x.ph));
            chk({tag, ".light_a"}, 32'(bus.light_a),    32'(x.la));
            chk({tag, ".light_b"}, 32'(bus.light_b),    32'(x.lb));
            chk({tag, ".count_a"}, 32'(bus.count_a),    32'(x.ca));
            chk({tag, ".count_b"}, 32'(bus.count_b),    32'(x.cb));
            chk({tag, ".ovf_a"},   32'(bus.overflow_a), 32'(x.oa));
            chk({tag, ".ovf_b"},   32'(bus.overflow_b), 32'(x.ob));
        end
    endtask

    // One clock of stimulus; the expectation set by the caller describes the post-edge state.
    task automatic drive(input bit t, input logic [NL-1:0] aa, input logic [NL-1:0] ab,
                         input bit pass, input bit frc, input string tag);
        bus.tick_in         = t;
        bus.car_arrived_a   = aa;
        bus.car_arrived_b   = ab;
        bus.car_pass_in     = pass;
        bus.force_switch_in = frc;
        push_exp();
        @(posedge clk);
        #1;
        bus.tick_in         = 1'b0;
        bus.car_arrived_a   = '0;
        bus.car_arrived_b   = '0;
        bus.car_pass_in     = 1'b0;
        bus.force_switch_in = 1'b0;
        pop_check(tag);
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b0;
        e_ph = A_GREEN;
        e_ca = '0;
        e_cb = '0;
        e_oa = '0;
        e_ob = '0;
        push_exp();
        #1;
        pop_check(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                 = 1'b1;
        bus.tick_in         = 1'b0;
        bus.car_arrived_a   = '0;
        bus.car_arrived_b   = '0;
        bus.car_pass_in     = 1'b0;
        bus.force_switch_in = 1'b0;
        #2;

        // Test 1: demand only on B, A empty -> 4/2/1 ticks then B_GREEN
        do_reset("t1_reset");
        for (int i = 1; i <= 3; i++) begin
            e_cb = 8'(i);
            drive(1'b0, 2'b00, 2'b01, 1'b0, 1'b0, "t1_arrive_b0");
        end
        for (int i = 1; i <= 3; i++) drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t1_agreen_hold");
        e_ph = A_YELLOW;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t1_agreen_end");
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t1_ayellow_hold");
        e_ph = RED_AB;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t1_ayellow_end");
        e_ph = B_GREEN;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t1_allred_end");
        e_cb = 8'h02;
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "t1_bgreen_pass");

        // Test 2: saturation and sticky overflow on a[1]
        do_reset("t2_reset");
        for (int i = 1; i <= 16; i++) begin
            e_ca = 8'((i > 15 ? 15 : i) << 4);
            e_oa = (i == 16) ? 2'b10 : 2'b00;
            drive(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, "t2_arrive_a1");
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "t2_ovf_sticky");

        // Test 3: simultaneous arrival and pass
        do_reset("t3_reset");
        e_ca = 8'h01;
        drive(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, "t3_arrive1");
        e_ca = 8'h02;
        drive(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, "t3_arrive2");
        drive(1'b0, 2'b01, 2'b00, 1'b1, 1'b0, "t3_inc_dec");
        e_ca = 8'h01;
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "t3_dec_only");

        // Test 4: green departures, forced end, no departures in yellow
        do_reset("t4_reset");
        e_ca = 8'h11;
        drive(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, "t4_load1");
        e_ca = 8'h21;
        drive(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, "t4_load2");
        e_ca = 8'h31;
        drive(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, "t4_load3");
        e_ca = 8'h20;
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "t4_pass1");
        e_ca = 8'h10;
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "t4_pass2");
        e_cb = 8'h01;
        drive(1'b0, 2'b00, 2'b01, 1'b0, 1'b0, "t4_arrive_b");
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "t4_force");
        for (int i = 1; i <= 3; i++) drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t4_force_min_hold");
        e_ph = A_YELLOW;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t4_force_end");
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "t4_yellow_pass");
`ifdef CAR_CROSSROAD_STATS_EN
        chk("t4_passed_a", 32'(bus.passed_a), 32'd3);
        chk("t4_passed_b", 32'(bus.passed_b), 32'd0);
`endif

        // Test 5: both roads loaded -> max green, then forced B end
        do_reset("t5_reset");
        for (int i = 1; i <= 5; i++) begin
            e_ca = 8'(i);
            e_cb = 8'(i);
            drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, "t5_load");
        end
        for (int t = 1; t <= 16; t++) begin
            e_ph = (t == 16) ? A_YELLOW : A_GREEN;
            drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_max_green");
        end
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_ayellow_hold");
        e_ph = RED_AB;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_ayellow_end");
        e_ph = B_GREEN;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_allred_end");
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_bgreen_tick1");
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "t5_bforce");
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_bgreen_tick2");
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_bgreen_tick3");
        e_ph = B_YELLOW;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t5_bgreen_tick4");

        // Test 6: reset mid B_YELLOW, then no partial phase resumes
        do_reset("t6_reset_midphase");
        drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "t6_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
